// File: rtl/z80_bus_pkg.sv
// Shared types for the tv80s bus target: trace entry layout, wait FSM states
// and wait-counter sizing.
package z80_bus_pkg;

  typedef struct packed {
    logic        is_io;
    logic [15:0] addr;
    logic [7:0]  data;
  } trace_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    HOLD  = 2'd2
  } wait_state_e;

  // Bits needed to hold a wait count of 0..max_wait.
  function automatic int cnt_width(input int max_wait);
    return (max_wait < 2) ? 1 : $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/z80_trace_fifo.sv
// Synchronous FIFO recording CPU writes, with a sticky overflow flag and a
// synchronous clear that overrides push and pop.
module z80_trace_fifo
  import z80_bus_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  trace_entry_t push_data,
  input  logic         ready,
  output logic         valid,
  output trace_entry_t data,
  output logic         overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  trace_entry_t mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         empty;
  logic         full;
  logic         pop;
  logic         wr_en;

  // Extra top bit distinguishes full from empty when the indices match.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = !empty && ready;
  assign wr_en = push && (!full || pop);
  assign valid = !empty;
  assign data  = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wptr <= wptr + PTR_ONE;
      if (pop)   rptr <= rptr + PTR_ONE;
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  // NOTE: storage has no reset; only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en && !clr) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/z80_bus_target.sv
// Memory/IO target for the tv80s bus: one byte array with an aliased IO page,
// per-class wait-state insertion, a backdoor loader and a CPU write trace.
module z80_bus_target
  import z80_bus_pkg::*;
#(
  parameter int          ADDR_W      = 16,
  parameter logic [7:0]  IO_PAGE     = 8'h10,
  parameter int          MEM_WAIT    = 0,
  parameter int          IO_WAIT     = 1,
  parameter int          TRACE_DEPTH = 8
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [15:0]       cpu_a,
  input  logic [7:0]        cpu_do,
  output logic [7:0]        cpu_di,
  input  logic              cpu_mreq_n,
  input  logic              cpu_iorq_n,
  input  logic              cpu_rd_n,
  input  logic              cpu_wr_n,
  input  logic              cpu_m1_n,
  input  logic              cpu_rfsh_n,
  output logic              cpu_wait_n,
  input  logic              bd_we,
  input  logic [ADDR_W-1:0] bd_addr,
  input  logic [7:0]        bd_data,
  output logic              trace_valid,
  input  logic              trace_ready,
  output logic [24:0]       trace_data,
  output logic              trace_overflow,
  input  logic              trace_clr
);

  localparam int CNT_W = cnt_width((MEM_WAIT > IO_WAIT) ? MEM_WAIT : IO_WAIT);
  localparam logic [CNT_W-1:0] MEM_CNT = CNT_W'(MEM_WAIT);
  localparam logic [CNT_W-1:0] IO_CNT  = CNT_W'(IO_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic mem_rd, mem_wr, io_rd, io_wr;
  logic access, wr_act, is_io_acc;

  // Refresh and interrupt-acknowledge cycles are filtered out here.
  assign mem_rd    = !cpu_mreq_n && !cpu_rd_n && cpu_rfsh_n;
  assign mem_wr    = !cpu_mreq_n && !cpu_wr_n;
  assign io_rd     = !cpu_iorq_n && !cpu_rd_n && cpu_m1_n;
  assign io_wr     = !cpu_iorq_n && !cpu_wr_n;
  assign access    = mem_rd || mem_wr || io_rd || io_wr;
  assign wr_act    = mem_wr || io_wr;
  assign is_io_acc = io_rd || io_wr;

  logic [15:0]       io_full;
  logic [ADDR_W-1:0] mem_addr, io_addr, wr_addr;

  assign io_full  = {IO_PAGE, cpu_a[7:0]};
  assign mem_addr = cpu_a[ADDR_W-1:0];
  assign io_addr  = io_full[ADDR_W-1:0];
  assign wr_addr  = io_wr ? io_addr : mem_addr;

  // Backdoor is captured on the rising edge and committed on the next falling
  // edge so the array has a single write port; reads forward the pending byte.
  logic              bd_pend;
  logic [ADDR_W-1:0] bd_addr_q;
  logic [7:0]        bd_data_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) bd_pend <= 1'b0;
    else            bd_pend <= bd_we;
  end

  always_ff @(posedge i_clk) begin
    bd_addr_q <= bd_addr;
    bd_data_q <= bd_data;
  end

  logic [7:0] mem [2**ADDR_W];
  logic [7:0] mem_q, io_q;

  // NOTE: both writes may hit one address; the later non-blocking assignment
  // takes effect, so the CPU write wins over the backdoor.
  always_ff @(negedge i_clk) begin
    if (bd_pend) mem[bd_addr_q] <= bd_data_q;
    if (wr_act)  mem[wr_addr]   <= cpu_do;
  end

  always_ff @(negedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      mem_q <= '0;
      io_q  <= '0;
    end else begin
      mem_q <= (bd_pend && bd_addr_q == mem_addr) ? bd_data_q : mem[mem_addr];
      io_q  <= (bd_pend && bd_addr_q == io_addr)  ? bd_data_q : mem[io_addr];
    end
  end

  assign cpu_di = !cpu_iorq_n ? io_q : mem_q;

  wait_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] load;

  assign load       = is_io_acc ? IO_CNT : MEM_CNT;
  assign cpu_wait_n = (state != STALL);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (access) begin
          cnt   <= load;
          state <= (load != '0) ? STALL : HOLD;
        end
        STALL: if (!access) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) state <= HOLD;
        end
        HOLD: if (!access) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // One trace entry per write cycle, on the first rising edge it is seen.
  logic         wr_q;
  logic         push;
  trace_entry_t push_entry;
  trace_entry_t fifo_data;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) wr_q <= 1'b0;
    else            wr_q <= wr_act;
  end

  assign push             = wr_act && !wr_q;
  assign push_entry.is_io = io_wr;
  assign push_entry.addr  = cpu_a;
  assign push_entry.data  = cpu_do;
  assign trace_data       = fifo_data;

  z80_trace_fifo #(.DEPTH(TRACE_DEPTH)) u_trace_fifo (
    .clk       (i_clk),
    .rst_n     (i_reset_n),
    .clr       (trace_clr),
    .push      (push),
    .push_data (push_entry),
    .ready     (trace_ready),
    .valid     (trace_valid),
    .data      (fifo_data),
    .overflow  (trace_overflow)
  );

endmodule

// File: tb/tb_z80_bus_target.sv
// Bus-level bench for z80_bus_target: emulates tv80s bus cycles, scoreboards
// read data and trace entries, and checks wait-state counts.
module tb_z80_bus_target;
  import z80_bus_pkg::*;

  localparam int MEM_WAIT = 3;
  localparam int IO_WAIT  = 2;
  localparam int DEPTH    = 4;

  logic        i_clk, i_reset_n;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_do, cpu_di;
  logic        cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n, cpu_rfsh_n;
  logic        cpu_wait_n;
  logic        bd_we;
  logic [15:0] bd_addr;
  logic [7:0]  bd_data;
  logic        trace_valid, trace_ready, trace_overflow, trace_clr;
  logic [24:0] trace_data;

  z80_bus_target #(
    .ADDR_W(16), .IO_PAGE(8'h10), .MEM_WAIT(MEM_WAIT), .IO_WAIT(IO_WAIT),
    .TRACE_DEPTH(DEPTH)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .cpu_a(cpu_a), .cpu_do(cpu_do),
    .cpu_di(cpu_di), .cpu_mreq_n(cpu_mreq_n), .cpu_iorq_n(cpu_iorq_n),
    .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n), .cpu_m1_n(cpu_m1_n),
    .cpu_rfsh_n(cpu_rfsh_n), .cpu_wait_n(cpu_wait_n), .bd_we(bd_we),
    .bd_addr(bd_addr), .bd_data(bd_data), .trace_valid(trace_valid),
    .trace_ready(trace_ready), .trace_data(trace_data),
    .trace_overflow(trace_overflow), .trace_clr(trace_clr)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int           n_cmp = 0;
  int           n_err = 0;
  trace_entry_t exp_trace [$];
  logic [7:0]   exp_rd [$];
  logic [7:0]   got_rd [$];
  trace_entry_t mon_e;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic trace_entry_t mk(input logic io, input logic [15:0] a, input logic [7:0] d);
    trace_entry_t e;
    e.is_io = io;
    e.addr  = a;
    e.data  = d;
    return e;
  endfunction

  // Monitor: pops a trace expectation on every handshake, and pairs up
  // captured read bytes with their expected values.
  always @(negedge i_clk) begin
    if (i_reset_n && trace_valid && trace_ready) begin
      if (exp_trace.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL trace_unexpected: got 0x%0h expected no entry", trace_data);
      end else begin
        mon_e = exp_trace.pop_front();
        check("trace_entry", 32'(trace_data), 32'(mon_e));
      end
    end
    while (exp_rd.size() > 0 && got_rd.size() > 0)
      check("read_data", 32'(got_rd.pop_front()), 32'(exp_rd.pop_front()));
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_bus();
    cpu_mreq_n = 1'b1; cpu_iorq_n = 1'b1; cpu_rd_n = 1'b1;
    cpu_wr_n   = 1'b1; cpu_m1_n   = 1'b1; cpu_rfsh_n = 1'b1;
  endtask

  task automatic bd_write(input logic [15:0] a, input logic [7:0] d);
    @(posedge i_clk); #1;
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge i_clk); #1;
    bd_we = 1'b0;
  endtask

  // One CPU read/write cycle; counts low cpu_wait_n samples and captures the
  // read byte once wait is released.
  task automatic bus_cycle(input bit io, input bit wr, input bit m1,
                           input logic [15:0] a, input logic [7:0] d,
                           input bit pop_with, output int waits);
    bit done;
    done  = 1'b0;
    waits = 0;
    @(posedge i_clk); #1;
    cpu_a = a; cpu_do = d; cpu_m1_n = !m1;
    if (io) cpu_iorq_n = 1'b0; else cpu_mreq_n = 1'b0;
    if (wr) cpu_wr_n = 1'b0;   else cpu_rd_n = 1'b0;
    if (pop_with) trace_ready = 1'b1;
    @(posedge i_clk); #1;
    if (pop_with) trace_ready = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge i_clk); #1;
      if (cpu_wait_n === 1'b0) waits++;
      else done = 1'b1;
    end
    check("wait_release", 32'(done), 32'd1);
    if (!wr) got_rd.push_back(cpu_di);
    @(posedge i_clk); #1;
    idle_bus();
  endtask

  // Refresh (rfsh=1) or interrupt-acknowledge (rfsh=0) cycle held 4 cycles.
  task automatic raw_cycle(input bit rfsh, input logic [15:0] a, output int waits);
    waits = 0;
    @(posedge i_clk); #1;
    cpu_a = a;
    if (rfsh) begin cpu_mreq_n = 1'b0; cpu_rfsh_n = 1'b0; end
    else      begin cpu_iorq_n = 1'b0; cpu_m1_n   = 1'b0; end
    repeat (4) begin
      @(negedge i_clk); #1;
      if (cpu_wait_n === 1'b0) waits++;
    end
    @(posedge i_clk); #1;
    idle_bus();
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    @(posedge i_clk); #1;
    trace_ready = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge i_clk); #1;
      if (!trace_valid) done = 1'b1;
    end
    trace_ready = 1'b0;
    check("drain_done", 32'(done), 32'd1);
  endtask

  int w;

  initial begin
    idle_bus();
    cpu_a = '0; cpu_do = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    trace_ready = 1'b0; trace_clr = 1'b0;
    i_reset_n = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_wait_n", 32'(cpu_wait_n), 32'd1);
    check("rst_trace_valid", 32'(trace_valid), 32'd0);
    check("rst_overflow", 32'(trace_overflow), 32'd0);
    check("rst_trace_data", 32'(trace_data), 32'd0);
    check("rst_cpu_di", 32'(cpu_di), 32'd0);
    i_reset_n = 1'b1;

    bd_write(16'h0000, 8'hAE);
    bd_write(16'hDCA6, 8'h49);

    // XOR (HL): opcode fetch, refresh, operand read; no writes.
    exp_rd.push_back(8'hAE);
    bus_cycle(1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, w);
    check("m1_wait", 32'(w), 32'd3);
    raw_cycle(1'b1, 16'h0000, w);
    check("rfsh_wait", 32'(w), 32'd0);
    exp_rd.push_back(8'h49);
    bus_cycle(1'b0, 1'b0, 1'b0, 16'hDCA6, 8'h00, 1'b0, w);
    check("mem_rd_wait", 32'(w), 32'd3);
    check("xor_no_trace", 32'(trace_valid), 32'd0);

    // LD (HL),A
    exp_trace.push_back(mk(1'b0, 16'h4000, 8'h5A));
    bus_cycle(1'b0, 1'b1, 1'b0, 16'h4000, 8'h5A, 1'b0, w);
    check("mem_wr_wait", 32'(w), 32'd3);
    check("ld_trace_valid", 32'(trace_valid), 32'd1);
    exp_rd.push_back(8'h5A);
    bus_cycle(1'b0, 1'b0, 1'b0, 16'h4000, 8'h00, 1'b0, w);

    // OUT (0x34),A with A = 0x77, then read the aliased byte both ways.
    exp_trace.push_back(mk(1'b1, 16'h7734, 8'h77));
    bus_cycle(1'b1, 1'b1, 1'b0, 16'h7734, 8'h77, 1'b0, w);
    check("io_wr_wait", 32'(w), 32'd2);
    exp_rd.push_back(8'h77);
    bus_cycle(1'b0, 1'b0, 1'b0, 16'h1034, 8'h00, 1'b0, w);
    exp_rd.push_back(8'h77);
    bus_cycle(1'b1, 1'b0, 1'b0, 16'hAB34, 8'h00, 1'b0, w);
    check("io_rd_wait", 32'(w), 32'd2);
    raw_cycle(1'b0, 16'h00FF, w);
    check("intack_wait", 32'(w), 32'd0);
    drain();
    check("trace_left_1", 32'(exp_trace.size()), 32'd0);

    // Five writes into a 4-deep FIFO with no pops: the fifth is dropped.
    for (int i = 0; i < 5; i++) begin
      if (i < DEPTH) exp_trace.push_back(mk(1'b0, 16'h5000 + 16'(i), 8'h10 + 8'(i)));
      bus_cycle(1'b0, 1'b1, 1'b0, 16'h5000 + 16'(i), 8'h10 + 8'(i), 1'b0, w);
      if (i == DEPTH - 1) check("ovf_before", 32'(trace_overflow), 32'd0);
    end
    check("ovf_after", 32'(trace_overflow), 32'd1);
    drain();
    check("trace_left_2", 32'(exp_trace.size()), 32'd0);
    check("ovf_sticky", 32'(trace_overflow), 32'd1);
    bus_cycle(1'b0, 1'b1, 1'b0, 16'h5010, 8'hEE, 1'b0, w);
    @(posedge i_clk); #1;
    trace_clr = 1'b1;
    @(posedge i_clk); #1;
    trace_clr = 1'b0;
    check("clr_valid", 32'(trace_valid), 32'd0);
    check("clr_overflow", 32'(trace_overflow), 32'd0);
    check("clr_data", 32'(trace_data), 32'd0);

    // Full FIFO, pop and push on the same edge: accepted, no overflow.
    for (int i = 0; i < DEPTH; i++) begin
      exp_trace.push_back(mk(1'b0, 16'h5100 + 16'(i), 8'h20 + 8'(i)));
      bus_cycle(1'b0, 1'b1, 1'b0, 16'h5100 + 16'(i), 8'h20 + 8'(i), 1'b0, w);
    end
    exp_trace.push_back(mk(1'b0, 16'h5104, 8'h24));
    bus_cycle(1'b0, 1'b1, 1'b0, 16'h5104, 8'h24, 1'b1, w);
    check("full_pop_ovf", 32'(trace_overflow), 32'd0);
    drain();
    check("trace_left_3", 32'(exp_trace.size()), 32'd0);

    // Backdoor and CPU write to one address in the same cycle: CPU wins.
    exp_trace.push_back(mk(1'b0, 16'h6000, 8'h11));
    fork
      bus_cycle(1'b0, 1'b1, 1'b0, 16'h6000, 8'h11, 1'b0, w);
      begin
        @(posedge i_clk); #1;
        bd_we = 1'b1; bd_addr = 16'h6000; bd_data = 8'h22;
        @(posedge i_clk); #1;
        bd_we = 1'b0;
      end
    join
    exp_rd.push_back(8'h11);
    bus_cycle(1'b0, 1'b0, 1'b0, 16'h6000, 8'h00, 1'b0, w);
    drain();

    // Asynchronous reset while stalling a write cycle.
    @(posedge i_clk); #1;
    cpu_a = 16'h7000; cpu_do = 8'h33; cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0;
    @(posedge i_clk); #1;
    @(negedge i_clk); #1;
    check("stall_before_rst", 32'(cpu_wait_n), 32'd0);
    check("push_before_rst", 32'(trace_valid), 32'd1);
    #2 i_reset_n = 1'b0;
    #1;
    check("rst_mid_wait_n", 32'(cpu_wait_n), 32'd1);
    check("rst_mid_trace", 32'(trace_valid), 32'd0);
    idle_bus();
    @(posedge i_clk); #1;
    i_reset_n = 1'b1;

    // Array contents survive reset.
    exp_rd.push_back(8'h5A);
    bus_cycle(1'b0, 1'b0, 1'b0, 16'h4000, 8'h00, 1'b0, w);
    check("post_rst_wait", 32'(w), 32'd3);

    repeat (3) @(posedge i_clk);
    #1;
    check("exp_rd_left", 32'(exp_rd.size()), 32'd0);
    check("got_rd_left", 32'(got_rd.size()), 32'd0);
    check("exp_trace_left", 32'(exp_trace.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/z80_bus_target.md
# z80_bus_target

Parametrised, synthesizable memory/IO target for the tv80s bus, replacing the ad-hoc 64 KiB array in per-opcode benches. It stores memory and an aliased IO page in one array, inserts a programmable number of wait states per access class, and records every CPU write in a trace FIFO. The FIFO lets benches check bus-level side effects instead of only peeking at final array contents. It sits between the tv80s core and the bench (or an FPGA top), with a backdoor port for preloading programs.

## Interface
- ADDR_W, 16: storage address width; array depth is 2**ADDR_W bytes.
- IO_PAGE, 8'h10: high address byte for IO accesses; IO address is {IO_PAGE, A[7:0]}, truncated to ADDR_W.
- MEM_WAIT, 0: wait cycles inserted on each memory read/write (0..15).
- IO_WAIT, 1: wait cycles inserted on each IO read/write (0..15).
- TRACE_DEPTH, 8: trace FIFO entries, power of two, 2..256.

Ports:
- i_clk in 1: single clock, shared with the CPU.
- i_reset_n in 1: asynchronous, active-low reset.
- cpu_a in 16: CPU address.
- cpu_do in 8: CPU write data.
- cpu_di out 8: read data to CPU.
- cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n, cpu_rfsh_n in 1 each: CPU strobes, all active-low.
- cpu_wait_n out 1: wait request to CPU.
- bd_we in 1, bd_addr in ADDR_W, bd_data in 8: backdoor write.
- trace_valid out 1, trace_ready in 1: trace pop handshake.
- trace_data out 25: {is_io, addr[15:0], data[7:0]}.
- trace_overflow out 1: sticky flag, set when a write is dropped.
- trace_clr in 1: synchronous flush of the FIFO and clear of trace_overflow.

## Operation
- Qualified accesses:
  - mem_rd: !mreq_n & !rd_n & rfsh_n.
  - mem_wr: !mreq_n & !wr_n.
  - io_rd: !iorq_n & !rd_n & m1_n.
  - io_wr: !iorq_n & !wr_n.
  - Refresh cycles and interrupt-acknowledge cycles (!iorq_n & !m1_n) are ignored: no wait, no trace entry.
- Read path:
  - Array read registered on the falling edge of i_clk, at cpu_a for memory and the IO address for IO, matching tv80s sampling.
  - cpu_di selects IO data while iorq_n is low, else memory data.
- Write path:
  - Array written on the falling edge while mem_wr or io_wr is active.
  - Backdoor write on the rising edge when bd_we is high. If both hit the same cycle, the CPU write lands last (falling edge) and wins.
- Wait FSM, rising edge:
  - IDLE: on the first cycle a qualified access is seen, load cnt with MEM_WAIT or IO_WAIT. Go to STALL if the value is non-zero, else HOLD.
  - STALL: cpu_wait_n = 0. cnt decrements each cycle; go to HOLD when cnt reaches 1.
  - HOLD: cpu_wait_n = 1. Return to IDLE when no qualified access is active.
  - If the strobes drop during STALL, return to IDLE and release wait.
- Trace:
  - A push occurs on the rising edge of the cycle where mem_wr|io_wr first becomes active (edge-detected). One entry per CPU write cycle, even though the array write repeats each falling edge.
  - Entry fields: is_io = io_wr, addr = cpu_a (IO uses the full cpu_a), data = cpu_do.
  - trace_valid = !empty. A pop occurs on trace_valid & trace_ready.
  - Full with no pop in the same cycle: the entry is dropped and trace_overflow is set.
  - Full with a simultaneous pop: the push is accepted and the count is unchanged.
  - trace_clr has priority over push and pop.

## Timing
- Reset values:
  - cpu_wait_n = 1, FSM = IDLE, cnt = 0.
  - FIFO empty, trace_valid = 0, trace_overflow = 0, trace_data = 0.
  - cpu_di = 0 until the first falling edge after reset.
  - Array contents are not reset.
- Reset asserted mid-access: wait releases immediately and the FSM returns to IDLE. An in-flight trace push is lost.
- cpu_wait_n falls on the rising edge after the strobe is seen. It stays low for exactly N cycles, where N = MEM_WAIT or IO_WAIT.
- Trace latency: an entry is visible on trace_valid the cycle after its push edge.
- Pointers are log2(TRACE_DEPTH) bits plus one wrap bit. Full is pointer equality with the wrap bits differing.

## Structure
- Shared package z80_bus_pkg:
  - trace_entry_t packed struct {is_io, addr, data}.
  - wait_state_e enum {IDLE, STALL, HOLD}.
  - Width function for the counter.
- One sub-module, z80_trace_fifo: parametrised synchronous FIFO with an overflow flag. Storage array and wait FSM stay in the top.

## Test plan
- Preload 0x0000 = 0xAE and 0xDCA6 = 0x49 via the backdoor. Run XOR (HL) with A = 0xF5 and HL = 0xDCA6 -> A = 0xBC, PC = 0x0001, no trace entry.
- LD (HL),A with HL = 0x4000, A = 0x5A -> mem[0x4000] = 0x5A; exactly one trace entry {0, 0x4000, 0x5A}.
- OUT (0x34),A with A = 0x77 and IO_WAIT = 2 -> mem[0x1034] = 0x77; cpu_wait_n low for 2 cycles; trace entry {1, A[15:8]=0x77, A[7:0]=0x34, 0x77}.
- MEM_WAIT = 3, single M1 fetch -> cpu_wait_n low for exactly 3 cycles; none during the refresh portion.
- TRACE_DEPTH = 4, 5 writes with trace_ready = 0 -> 4 entries held, trace_overflow = 1. trace_clr -> trace_valid = 0, trace_overflow = 0.
- Full FIFO with trace_ready = 1 and a write in the same cycle -> count stays 4, no overflow. Async reset during STALL -> cpu_wait_n = 1 immediately.
